storage_compare_monitor: RTL and testbench

- Downstream consumer of the three storage-element outputs: gated D latch (Qa), posedge D flip-flop (Qb) and negedge D flip-flop (Qc), all driven from a shared D and clk.
- On a start pulse, samples Qa/Qb/Qc on every posedge clk for a fixed window of WINDOW cycles.
- Counts pairwise disagreements in saturating counters, then signals completion with a one-cycle done pulse.
- Results hold until the next run, so the counts can be read from switches/LEDs or by a testbench.

---
 rtl/storage_compare_monitor_pkg.sv | 19 +
 rtl/storage_compare_monitor_if.sv | 44 ++++
 rtl/storage_compare_monitor_sat_counter.sv | 23 ++
 rtl/storage_compare_monitor.sv | 97 +++++++++
 tb/tb_storage_compare_monitor.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/storage_compare_monitor_pkg.sv
// storage_mon_pkg: FSM encoding, default sizing and window-counter width helper
// shared by the storage_compare_monitor block.
package storage_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int CNT_W_DEF  = 8;
    localparam int WINDOW_DEF = 16;

    // Wide enough to hold WINDOW itself, since the counter steps past WINDOW-1 on exit.
    function automatic int win_w(input int window);
        return $clog2(window + 1);
    endfunction

endpackage

// File: rtl/storage_compare_monitor_if.sv
// storage_compare_monitor_if: start/sample inputs and result outputs of the monitor.
// MON_EDGE_CNT_EN adds the edge_b result.
interface storage_compare_monitor_if
    import storage_mon_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic             start;
    logic             Qa;
    logic             Qb;
    logic             Qc;
    logic             busy;
    logic             done;
    logic             sat;
    logic [CNT_W-1:0] cnt_ab;
    logic [CNT_W-1:0] cnt_bc;
    logic [CNT_W-1:0] cnt_ac;

`ifdef MON_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_b;

    modport master (
        output start, Qa, Qb, Qc,
        input  busy, done, sat, cnt_ab, cnt_bc, cnt_ac, edge_b
    );

    modport slave (
        input  start, Qa, Qb, Qc,
        output busy, done, sat, cnt_ab, cnt_bc, cnt_ac, edge_b
    );
`else
    modport master (
        output start, Qa, Qb, Qc,
        input  busy, done, sat, cnt_ab, cnt_bc, cnt_ac
    );

    modport slave (
        input  start, Qa, Qb, Qc,
        output busy, done, sat, cnt_ab, cnt_bc, cnt_ac
    );
`endif

endinterface

// File: rtl/storage_compare_monitor_sat_counter.sv
// sat_counter: W-bit up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q,
    output logic         at_max
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    assign q      = q_q;
    assign at_max = &q_q;

    always_comb q_d = clr ? '0 : (inc && !at_max) ? q_q + 1'b1 : q_q;

    always_ff @(posedge clk) q_q <= !reset_n ? '0 : q_d;

endmodule

// File: rtl/storage_compare_monitor.sv
// storage_compare_monitor: counts pairwise disagreements of Qa/Qb/Qc over a fixed
// window after start. MON_EDGE_CNT_EN adds a Qb transition counter (edge_b).
module storage_compare_monitor
    import storage_mon_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = WINDOW_DEF
) (
    input logic                      clk,
    input logic                      reset_n,
    storage_compare_monitor_if.slave bus
);

    localparam int WW = win_w(WINDOW);

    state_e        state_q;
    state_e        state_d;
    logic [WW-1:0] win_q;
    logic [WW-1:0] win_d;
    logic          qa_s;
    logic          qb_s;
    logic          qc_s;
    logic          run;
    logic          clr;
    logic          max_ab;
    logic          max_bc;
    logic          max_ac;

    assign run = state_q == RUN;
    assign clr = state_q == IDLE && bus.start;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        if (clr) begin
            state_d = RUN;
            win_d   = '0;
        end else if (run) begin
            win_d   = win_q + 1'b1;
            state_d = win_q == WW'(WINDOW - 1) ? DONE : RUN;
        end else if (state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            win_q   <= '0;
            qa_s    <= 1'b0;
            qb_s    <= 1'b0;
            qc_s    <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            qa_s    <= bus.Qa;
            qb_s    <= bus.Qb;
            qc_s    <= bus.Qc;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_ab (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(run && (qa_s != qb_s)),
        .q(bus.cnt_ab), .at_max(max_ab)
    );

    sat_counter #(.W(CNT_W)) u_cnt_bc (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(run && (qb_s != qc_s)),
        .q(bus.cnt_bc), .at_max(max_bc)
    );

    sat_counter #(.W(CNT_W)) u_cnt_ac (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(run && (qa_s != qc_s)),
        .q(bus.cnt_ac), .at_max(max_ac)
    );

    assign bus.busy = run;
    assign bus.done = state_q == DONE;

`ifdef MON_EDGE_CNT_EN
    logic qb_d;
    logic max_eb;

    always_ff @(posedge clk) qb_d <= !reset_n ? 1'b0 : qb_s;

    sat_counter #(.W(CNT_W)) u_cnt_eb (
        .clk(clk), .reset_n(reset_n), .clr(clr), .inc(run && (qb_s != qb_d)),
        .q(bus.edge_b), .at_max(max_eb)
    );

    assign bus.sat = max_ab | max_bc | max_ac | max_eb;
`else
    // Counters only grow between clears, so "reached all-ones this run" is just "is all-ones now".
    assign bus.sat = max_ab | max_bc | max_ac;
`endif

endmodule

// File: tb/tb_storage_compare_monitor.sv
// tb_storage_compare_monitor: directed/random runs on an 8-bit and a 3-bit instance,
// checked against a per-window mismatch-count model.
module tb_storage_compare_monitor;

    localparam int W = 16;

    logic clk = 1'b0;
    logic reset_n, start, qa, qb, qc;
    int   pass_n = 0;
    int   total_n = 0;
    int   fail_n = 0;

    always #5 clk = ~clk;

    storage_compare_monitor_if #(.CNT_W(8)) bus8 ();
    storage_compare_monitor_if #(.CNT_W(3)) bus3 ();

    assign bus8.start = start;
    assign bus8.Qa    = qa;
    assign bus8.Qb    = qb;
    assign bus8.Qc    = qc;
    assign bus3.start = start;
    assign bus3.Qa    = qa;
    assign bus3.Qb    = qb;
    assign bus3.Qc    = qc;

    storage_compare_monitor #(.CNT_W(8), .WINDOW(W)) dut8 (.clk(clk), .reset_n(reset_n), .bus(bus8));
    storage_compare_monitor #(.CNT_W(3), .WINDOW(W)) dut3 (.clk(clk), .reset_n(reset_n), .bus(bus3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int clip(input int n, input int m);
        return n > m ? m : n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy8"}, bus8.busy, 0);
        chk({tag, " done8"}, bus8.done, 0);
        chk({tag, " sat8"}, bus8.sat, 0);
        chk({tag, " cnts8"}, {bus8.cnt_ab, bus8.cnt_bc, bus8.cnt_ac}, 0);
        chk({tag, " sat3"}, bus3.sat, 0);
        chk({tag, " cnts3"}, {bus3.cnt_ab, bus3.cnt_bc, bus3.cnt_ac}, 0);
`ifdef MON_EDGE_CNT_EN
        chk({tag, " edge8"}, bus8.edge_b, 0);
`endif
    endtask

    task automatic chk_results(input string tag, input int nab, input int nbc, input int nac, input int neb);
        chk({tag, " cnt_ab8"}, bus8.cnt_ab, clip(nab, 255));
        chk({tag, " cnt_bc8"}, bus8.cnt_bc, clip(nbc, 255));
        chk({tag, " cnt_ac8"}, bus8.cnt_ac, clip(nac, 255));
        chk({tag, " cnt_ab3"}, bus3.cnt_ab, clip(nab, 7));
        chk({tag, " cnt_bc3"}, bus3.cnt_bc, clip(nbc, 7));
        chk({tag, " cnt_ac3"}, bus3.cnt_ac, clip(nac, 7));
`ifdef MON_EDGE_CNT_EN
        chk({tag, " edge8"}, bus8.edge_b, clip(neb, 255));
        chk({tag, " edge3"}, bus3.edge_b, clip(neb, 7));
        chk({tag, " sat8"}, bus8.sat, (nab >= 255 || nbc >= 255 || nac >= 255 || neb >= 255));
        chk({tag, " sat3"}, bus3.sat, (nab >= 7 || nbc >= 7 || nac >= 7 || neb >= 7));
`else
        chk({tag, " sat8"}, bus8.sat, (nab >= 255 || nbc >= 255 || nac >= 255));
        chk({tag, " sat3"}, bus3.sat, (nab >= 7 || nbc >= 7 || nac >= 7));
        if (neb < 0) $display("unreachable");
`endif
    endtask

    // mode: 0 all ones, 1 a=1 b=0 c=0, 2 a=1 b=0 c=1, 3 random, 4 random a/c with b toggling.
    // poke: extra start pulse present at edge k+poke (0 = none); hold keeps start high.
    task automatic run_window(input string tag, input int mode, input int poke, input bit hold);
        logic a[W], b[W], c[W];
        logic pb, prev;
        int   nab, nbc, nac, neb, busy_bad;
        pb = qb;
        nab = 0; nbc = 0; nac = 0; neb = 0; busy_bad = 0;
        for (int j = 0; j < W; j++) begin
            prev = j == 0 ? pb : b[j-1];
            case (mode)
                0:       {a[j], b[j], c[j]} = 3'b111;
                1:       {a[j], b[j], c[j]} = 3'b100;
                2:       {a[j], b[j], c[j]} = 3'b101;
                3:       {a[j], b[j], c[j]} = 3'($urandom_range(0, 7));
                default: {a[j], b[j], c[j]} = {1'($urandom), ~prev, 1'($urandom)};
            endcase
            nab += int'(a[j] != b[j]);
            nbc += int'(b[j] != c[j]);
            nac += int'(a[j] != c[j]);
            neb += int'(b[j] != prev);
        end
        start = 1'b1;
        for (int j = 0; j < W; j++) begin
            qa = a[j]; qb = b[j]; qc = c[j];
            step();
            start = hold || (j + 1 == poke);
            if (bus8.busy !== 1'b1 || bus8.done !== 1'b0 || bus3.busy !== 1'b1) busy_bad++;
        end
        chk({tag, " busy window"}, busy_bad, 0);
        {qa, qb, qc} = 3'($urandom_range(0, 7));
        step();
        chk({tag, " done8"}, bus8.done, 1);
        chk({tag, " done3"}, bus3.done, 1);
        chk({tag, " busy at done"}, bus8.busy, 0);
        chk_results(tag, nab, nbc, nac, neb);
        step();
        chk({tag, " done one cycle"}, bus8.done, 0);
        chk({tag, " idle after done"}, bus8.busy, 0);
        if (hold) begin
            step();
            chk({tag, " back-to-back restart"}, bus8.busy, 1);
            chk({tag, " restart clears"}, {bus8.cnt_ab, bus8.cnt_bc, bus8.cnt_ac}, 0);
            start = 1'b0;
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            chk_idle_zero({tag, " reset after restart"});
        end else begin
            for (int i = 0; i < 5; i++) begin
                {qa, qb, qc} = 3'($urandom_range(0, 7));
                step();
            end
            chk({tag, " idle hold"}, {bus8.busy, bus8.done}, 0);
            chk_results({tag, " hold"}, nab, nbc, nac, neb);
        end
    endtask

    initial begin
        int seen_done;
        reset_n = 1'b0;
        start = 1'b0;
        {qa, qb, qc} = 3'($urandom_range(0, 7));
        step();
        {qa, qb, qc} = 3'($urandom_range(0, 7));
        step();
        chk_idle_zero("reset");
        reset_n = 1'b1;
        step();

        run_window("ones", 0, 0, 1'b0);
        run_window("a_only", 1, 0, 1'b0);
        run_window("b_only", 2, 0, 1'b0);
        for (int r = 0; r < 4; r++) run_window("random", 3, 0, 1'b0);
        run_window("toggle_b", 4, 0, 1'b0);
        run_window("start_in_run", 3, 5, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0;
        for (int j = 0; j < 7; j++) begin
            {qa, qb, qc} = 3'($urandom_range(0, 7));
            step();
        end
        chk("partial run busy", bus8.busy, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk_idle_zero("mid-run reset");
        seen_done = 0;
        for (int i = 0; i < 24; i++) begin
            {qa, qb, qc} = 3'($urandom_range(0, 7));
            step();
            seen_done += int'(bus8.done | bus3.done | bus8.busy);
        end
        chk("no done after reset", seen_done, 0);

        run_window("held_start", 3, 0, 1'b1);

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
